divider_share_ctrl: RTL
=======================

# divider_share_ctrl

Round-robin scheduler that shares one combinational 16/8 array divider (exact or approximate variant) among NREQ requesters. Each requester gets a valid/ready request channel and a valid/ready response channel. The block registers operands, holds them stable on the divider inputs for a programmable settle time, then captures quotient and remainder. Divide-by-zero and quotient overflow, which the array cannot represent, are detected up front and answered without using the divider.

## Interface
- NREQ, 4: number of requesters, from 2 to 8.
- DIV_WAIT, 1: settle cycles the divider inputs are held before capture, from 1 to 15.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  request accepted; at most one bit high.
- req_n  in  16*NREQ  dividend; requester i uses bits [16i+15:16i].
- req_d  in  8*NREQ  divisor; requester i uses bits [8i+7:8i].
- rsp_valid  out  NREQ  response for requester i; at most one bit high.
- rsp_ready  in  NREQ  response consumed, one bit per requester.
- rsp_q  out  8  quotient.
- rsp_r  out  8  remainder.
- rsp_dz  out  1  divide-by-zero flag.
- rsp_ovf  out  1  quotient-overflow flag.
- div_n  out  16  dividend to the divider instance (its n).
- div_d  out  8  divisor to the divider instance (its d).
- div_q  in  8  quotient from the divider instance (its q).
- div_r  in  8  remainder from the divider instance (its r).
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - Grant goes to the first requester with req_valid high, searching upward from ptr with wrap at NREQ.
  - req_ready[grant] is asserted combinationally; all other bits stay 0.
  - req_ready is all-zero outside IDLE and whenever rst is high.
- **Accept** (req_valid[g] and req_ready[g] at an edge)
  - Register owner=g, opn=req_n[g], opd=req_d[g].
  - Exception check on the registered operands:
    - dz = (opd==0).
    - ovf = !dz and (opn[15:8] >= opd).
  - If dz or ovf: go to RESP; rsp_q=8'hFF, rsp_r=opn[7:0], flags set accordingly.
  - Otherwise: go to WAIT with cnt=DIV_WAIT-1.
- **div_n / div_d**
  - Registered outputs, loaded with opn/opd at accept.
  - Held constant until the next accept; they are never loaded on an exception request (hold previous value).
  - Reset value 0.
- **WAIT**
  - cnt decrements each cycle.
  - In the cycle where cnt==0: capture div_q into rsp_q and div_r into rsp_r, clear both flags, go to RESP.
- **RESP**
  - rsp_valid[owner]=1.
  - When rsp_ready[owner] is seen at an edge: go to IDLE, ptr=(owner+1) mod NREQ, rsp_valid clears.
  - rsp_q, rsp_r and the flags hold until the next response is loaded.
- rsp_ready bits for non-owners are ignored.
- Divider outputs are forwarded unmodified; approximation error is the divider's property and is not checked here.

## Timing
- Reset values: state=IDLE, ptr=0, cnt=0, busy=0, rsp_valid=0, rsp_q=0, rsp_r=0, rsp_dz=0, rsp_ovf=0, div_n=0, div_d=0, req_ready=0.
- Normal latency: accept at edge T; rsp_valid is high from the cycle after edge T+DIV_WAIT.
- Exception latency: rsp_valid is high in the cycle after edge T; the divider is not used.
- A new accept is possible in the first cycle after the response handshake edge (IDLE).
- Minimum spacing between accepts:
  - normal: DIV_WAIT+2 cycles;
  - exception: 2 cycles.
- A requester withdrawing req_valid before acceptance is legal; the grant is recomputed every IDLE cycle.
- rst in any state aborts the transaction: all registers go to reset values at that edge, and an in-flight response is lost.
- Simultaneous rsp handshake and new req_valid in the same cycle: no accept that cycle, because the block is in RESP.

## Test plan
- Single divide, DIV_WAIT=1, exact divider, requester 0: n=1000, d=7 -> rsp_valid[0] rises 2 cycles after accept; q=142, r=6; flags 0.
- Divide by zero, requester 2: n=0x1234, d=0 -> rsp_valid[2] one cycle after accept; q=0xFF, r=0x34, dz=1, ovf=0; div_n/div_d unchanged.
- Overflow: n=0x0A00, d=0x0A -> ovf=1, dz=0, q=0xFF, r=0x00. Boundary: n=0x09FF, d=0x0A -> no overflow; q=0xFF, r=0x09.
- Fairness: all 4 requesters hold req_valid continuously -> accepts occur in order 0,1,2,3,0; no requester is granted twice in succession while others wait.
- Backpressure and settle, DIV_WAIT=3: hold rsp_ready low 5 cycles -> rsp_valid and rsp_q/rsp_r stable; req_ready stays 0; div_n/div_d stay constant through WAIT.
- Reset mid-WAIT: assert rst one cycle after accept -> next cycle all outputs at reset values, no response; a fresh request then completes normally with ptr=0 priority.

Source files
------------

// File: rtl/divider_share_ctrl.sv
// Round-robin arbiter that time-shares one combinational 16/8 array divider
// among NREQ requesters. Operands are held on the divider inputs for DIV_WAIT
// cycles before quotient/remainder are captured. Divide-by-zero and quotient
// overflow are answered directly without using the divider.
module divider_share_ctrl #(
    parameter int NREQ     = 4,
    parameter int DIV_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_n,
    input  logic [8*NREQ-1:0]    req_d,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [7:0]           rsp_q,
    output logic [7:0]           rsp_r,
    output logic                 rsp_dz,
    output logic                 rsp_ovf,
    output logic [15:0]          div_n,
    output logic [7:0]           div_d,
    input  logic [7:0]           div_q,
    input  logic [7:0]           div_r,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [3:0]    cnt;

    logic [PW-1:0] gnt;
    logic          gnt_hit;
    int            idx;
    logic [15:0]   sel_n;
    logic [7:0]    sel_d;
    logic          sel_dz;
    logic          sel_ovf;

    // Grant: first valid requester searching upward from ptr, wrapping at NREQ.
    always_comb begin
        gnt     = '0;
        gnt_hit = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_hit && req_valid[idx]) begin
                gnt_hit = 1'b1;
                gnt     = PW'(idx);
            end
        end
    end

    // Granted operands and the exceptions the array cannot represent:
    // a quotient fits in 8 bits only when the dividend high byte is below d.
    always_comb begin
        sel_n   = req_n[16*int'(gnt) +: 16];
        sel_d   = req_d[8*int'(gnt) +: 8];
        sel_dz  = (sel_d == 8'd0);
        sel_ovf = !sel_dz && (sel_n[15:8] >= sel_d);
    end

    // Ready only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_hit && !rst)
            req_ready = NREQ'(1) << gnt;
    end

    // Control FSM with registered response, divider operands and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= '0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_dz    <= 1'b0;
            rsp_ovf   <= 1'b0;
            div_n     <= '0;
            div_d     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_hit) begin
                        owner <= gnt;
                        busy  <= 1'b1;
                        if (sel_dz || sel_ovf) begin
                            // Divider operands keep their previous value here.
                            rsp_q     <= 8'hFF;
                            rsp_r     <= sel_n[7:0];
                            rsp_dz    <= sel_dz;
                            rsp_ovf   <= sel_ovf;
                            rsp_valid <= NREQ'(1) << gnt;
                            state     <= RESP;
                        end else begin
                            div_n <= sel_n;
                            div_d <= sel_d;
                            cnt   <= 4'(DIV_WAIT - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        rsp_dz    <= 1'b0;
                        rsp_ovf   <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        ptr       <= (int'(owner) == NREQ - 1) ? '0 : owner + PW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
